// File: rtl/uart_defs.sv
// uart_defs: FSM encodings and default frame/baud constants shared by the UART tx and rx paths
package uart_defs;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int DEF_DBIT = 8;
  localparam int DEF_SB_TICK = 16;
  localparam int OS_RATE = 16;
  localparam int DEF_BAUD_DIV = 163;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: circular buffer with registered full/empty flags
module uart_fifo #(
  parameter int W = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  input  logic [W-1:0] w_data,
  output logic [W-1:0] r_data,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic do_wr, do_rd;
  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;
  assign r_data = mem[rp];
  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= w_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_wr) wp <= wp + AW'(1);
      if (do_rd) rp <= rp + AW'(1);
      if (do_wr && !do_rd) begin
        empty <= 1'b0;
        full <= (wp + AW'(1)) == rp;
      end else if (do_rd && !do_wr) begin
        full <= 1'b0;
        empty <= (rp + AW'(1)) == wp;
      end
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 serial transmitter with 16x oversampled bit timing
module uart_tx_fifo
  import uart_defs::*;
#(
  parameter int DBIT = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK,
  parameter int BAUD_DIV = DEF_BAUD_DIV,
  parameter int FIFO_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_uart,
  input  logic [DBIT-1:0] w_data,
  output logic            tx_full,
  output logic            tx_empty,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);
  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam int SW = $clog2(SB_TICK + OS_RATE);
  localparam int NW = $clog2(DBIT + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [SW-1:0] s, s_n;
  logic [NW-1:0] n, n_n;
  logic [DBIT-1:0] b, b_n, head;
  logic pop, s_tick, tx_n;
  uart_fifo #(.W(DBIT), .AW(FIFO_W)) fifo (
    .clk(clk), .reset(reset), .wr(wr_uart), .rd(pop), .w_data(w_data),
    .r_data(head), .full(tx_full), .empty(tx_empty)
  );
  assign s_tick = state != IDLE && cnt == CW'(BAUD_DIV - 1);
  assign tx_busy = state != IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      s <= '0;
      n <= '0;
      b <= '0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= (state == IDLE || s_tick) ? '0 : cnt + CW'(1);
      s <= s_n;
      n <= n_n;
      b <= b_n;
      tx <= tx_n;
    end
  always_comb begin
    state_n = state;
    s_n = s;
    n_n = n;
    b_n = b;
    pop = 1'b0;
    case (state)
      IDLE:
        if (!tx_empty) begin
          pop = 1'b1;
          b_n = head;
          s_n = '0;
          n_n = '0;
          state_n = START;
        end
      START:
        if (s_tick) begin
          s_n = s == SW'(OS_RATE - 1) ? '0 : s + SW'(1);
          state_n = s == SW'(OS_RATE - 1) ? DATA : START;
        end
      DATA:
        if (s_tick) begin
          if (s == SW'(OS_RATE - 1)) begin
            s_n = '0;
            b_n = b >> 1;
            n_n = n + NW'(1);
            state_n = n == NW'(DBIT - 1) ? STOP : DATA;
          end else s_n = s + SW'(1);
        end
      default:
        if (s_tick) begin
          s_n = s + SW'(1);
          state_n = s == SW'(SB_TICK - 1) ? IDLE : STOP;
        end
    endcase
  end
  // line level is registered from the next state so it changes on the same edge as the FSM
  always_comb begin
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? b_n[0] : 1'b1;
    tx_done_tick = state == STOP && s_tick && s == SW'(SB_TICK - 1);
  end
endmodule
